// File: rtl/npc_unit.sv
// Next-PC select for the single-cycle datapath: NPC/PCLink are zero-latency combinational, no backpressure.
// Redirect is the only state: one cycle after a non-sequential NPC, cleared asynchronously by rst_n.
module npc_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:2] PC,
  input  logic [25:0] dout,
  input  logic [1:0]  NPCOp,
  input  logic        Zero,
  input  logic [31:0] RData1,
  output logic [31:2] NPC,
  output logic [31:2] PCLink,
  output logic        Redirect
);

  localparam logic [1:0] OP_SEQ = 2'b00;
  localparam logic [1:0] OP_BEQ = 2'b01;
  localparam logic [1:0] OP_J   = 2'b10;
  localparam logic [1:0] OP_JR  = 2'b11;

  logic [31:2] pc_plus1;
  logic [31:2] br_off;
  logic        redirect_nxt;
  logic        unused_rdata_lo;

  assign pc_plus1 = PC + 30'd1;
  // Word-granular offset: sign-extending the 16-bit field is the byte offset imm<<2.
  assign br_off   = {{14{dout[15]}}, dout[15:0]};
  assign PCLink   = pc_plus1;

  // The byte-offset bits of the jr target are meaningless on a word-addressed PC.
  assign unused_rdata_lo = ^RData1[1:0];

  always_comb begin
    NPC = pc_plus1;
    unique case (NPCOp)
      OP_SEQ: NPC = pc_plus1;
      OP_BEQ: NPC = Zero ? (pc_plus1 + br_off) : pc_plus1;
      OP_J:   NPC = {pc_plus1[31:28], dout[25:0]};
      OP_JR:  NPC = RData1[31:2];
      default: NPC = pc_plus1;
    endcase
  end

  assign redirect_nxt = (NPC != pc_plus1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Redirect <= 1'b0;
    end else begin
      Redirect <= redirect_nxt;
    end
  end

endmodule

// File: tb/tb_npc_unit.sv
// Bench for npc_unit: directed plan steps plus random ops against a byte-address reference model.
module tb_npc_unit;

  logic        clk;
  logic        rst_n;
  logic [31:2] PC;
  logic [25:0] dout;
  logic [1:0]  NPCOp;
  logic        Zero;
  logic [31:0] RData1;
  logic [31:2] NPC;
  logic [31:2] PCLink;
  logic        Redirect;

  int checks;
  int errors;

  npc_unit dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .dout(dout), .NPCOp(NPCOp),
    .Zero(Zero), .RData1(RData1), .NPC(NPC), .PCLink(PCLink), .Redirect(Redirect)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model works on 32-bit byte addresses, then drops the two zero bits.
  function automatic logic [29:0] model_npc(input logic [29:0] pc, input logic [25:0] d,
                                            input logic [1:0] op, input logic z,
                                            input logic [31:0] rs);
    logic [31:0] byte_pc, seq, tgt, off;
    byte_pc = {pc, 2'b00};
    seq     = byte_pc + 32'd4;
    off     = {{16{d[15]}}, d[15:0]} << 2;
    case (op)
      2'd0:    tgt = seq;
      2'd1:    tgt = z ? seq + off : seq;
      2'd2:    tgt = {seq[31:28], d, 2'b00};
      default: tgt = rs & 32'hFFFF_FFFC;
    endcase
    return tgt[31:2];
  endfunction

  function automatic logic [29:0] model_link(input logic [29:0] pc);
    logic [31:0] seq;
    seq = {pc, 2'b00} + 32'd4;
    return seq[31:2];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [29:0] pc, input logic [25:0] d, input logic [1:0] op,
                       input logic z, input logic [31:0] rs);
    PC = pc; dout = d; NPCOp = op; Zero = z; RData1 = rs;
  endtask

  // Directed step: literal expectations from the plan, cross-checked against the model.
  task automatic dir(input string tag, input logic [29:0] pc, input logic [25:0] d,
                     input logic [1:0] op, input logic z, input logic [31:0] rs,
                     input logic [29:0] exp_npc, input logic exp_redir);
    drive(pc, d, op, z, rs);
    #1;
    check({tag, "_npc"}, {2'b00, NPC}, {2'b00, exp_npc});
    check({tag, "_model"}, {2'b00, NPC}, {2'b00, model_npc(pc, d, op, z, rs)});
    check({tag, "_link"}, {2'b00, PCLink}, {2'b00, model_link(pc)});
    @(posedge clk);
    #1;
    check({tag, "_redir"}, {31'd0, Redirect}, {31'd0, exp_redir});
  endtask

  task automatic rnd_step();
    logic [29:0] pc;
    logic [25:0] d;
    logic [1:0]  op;
    logic        z;
    logic [31:0] rs;
    logic [29:0] en;
    pc = $urandom();
    if ($urandom_range(0, 15) == 0) pc = 30'h3FFF_FFFF;
    d  = $urandom();
    if ($urandom_range(0, 7) == 0) d[15:0] = 16'h0000;
    op = 2'($urandom_range(0, 3));
    z  = 1'($urandom_range(0, 1));
    rs = $urandom();
    if ($urandom_range(0, 7) == 0) rs = {model_link(pc), 2'($urandom_range(0, 3))};
    drive(pc, d, op, z, rs);
    #1;
    en = model_npc(pc, d, op, z, rs);
    check("rnd_npc", {2'b00, NPC}, {2'b00, en});
    check("rnd_link", {2'b00, PCLink}, {2'b00, model_link(pc)});
    @(posedge clk);
    #1;
    check("rnd_redir", {31'd0, Redirect}, {31'd0, en != model_link(pc)});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(30'd0, 26'd0, 2'b00, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    check("reset_redir", {31'd0, Redirect}, 32'd0);
    check("reset_npc", {2'b00, NPC}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    dir("seq",      30'd0, 26'd0,  2'b00, 1'b0, 32'd0, 30'd1, 1'b0);
    dir("beq_nt",   30'd0, 26'd2,  2'b01, 1'b0, 32'd0, 30'd1, 1'b0);
    dir("beq_t2",   30'd0, 26'd2,  2'b01, 1'b1, 32'd0, 30'd3, 1'b1);
    dir("beq_t3",   30'd0, 26'd3,  2'b01, 1'b1, 32'd0, 30'd4, 1'b1);
    dir("beq_t4",   30'd0, 26'd4,  2'b01, 1'b1, 32'd0, 30'd5, 1'b1);
    dir("beq_t16",  30'd0, 26'd16, 2'b01, 1'b1, 32'd0, 30'd17, 1'b1);
    dir("beq_off0", 30'd7, 26'd0,  2'b01, 1'b1, 32'd0, 30'd8, 1'b0);
    dir("beq_back", 30'h100, 26'h0FFFF, 2'b01, 1'b1, 32'd0, 30'h100, 1'b1);
    check("beq_back_link", {2'b00, PCLink}, 32'h101);
    dir("seq_zero_ign", 30'd5, 26'h0FFFF, 2'b00, 1'b1, 32'd0, 30'd6, 1'b0);
    dir("j_16",     30'd0, 26'd16, 2'b10, 1'b0, 32'd0, 30'd16, 1'b1);
    dir("j_hi",     30'h3000_0000, 26'd5, 2'b10, 1'b0, 32'd0, 30'h3000_0005, 1'b1);
    dir("jr_16",    30'h3000_0000, 26'd5, 2'b11, 1'b0, 32'd16, 30'd4, 1'b1);
    dir("jr_13",    30'h3000_0000, 26'd5, 2'b11, 1'b1, 32'h0000_0013, 30'd4, 1'b1);
    dir("jr_seq",   30'd3, 26'd0, 2'b11, 1'b0, 32'h0000_0012, 30'd4, 1'b0);
    dir("wrap",     30'h3FFF_FFFF, 26'd0, 2'b00, 1'b0, 32'd0, 30'd0, 1'b0);
    check("wrap_link", {2'b00, PCLink}, 32'd0);

    // Mid-cycle asynchronous reset while a redirecting op is held.
    dir("pre_rst",  30'd0, 26'd16, 2'b10, 1'b0, 32'd0, 30'd16, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_redir", {31'd0, Redirect}, 32'd0);
    check("async_rst_npc", {2'b00, NPC}, 32'd16);
    @(posedge clk);
    #1;
    check("hold_rst_redir", {31'd0, Redirect}, 32'd0);
    check("hold_rst_npc", {2'b00, NPC}, 32'd16);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_redir", {31'd0, Redirect}, 32'd1);

    for (int i = 0; i < 300; i++) rnd_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
